// File: rtl/ponylink_rx_checker_pkg.sv
// Shared types and error codes for the ponylink receive-side checker.
package ponylink_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_DATA    = 3'd1;
    localparam logic [2:0] ERR_USER    = 3'd2;
    localparam logic [2:0] ERR_LAST    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_STABLE  = 3'd5;
    localparam logic [2:0] ERR_LINK    = 3'd6;
    localparam logic [2:0] ERR_EXTRA   = 3'd7;

    // Picks the single cause reported for a RUN cycle. A link drop outranks
    // everything; a stability violation outranks the beat compare; timeout
    // can only fire on a cycle without a handshake.
    function automatic logic [2:0] err_select(
        input logic link_drop,
        input logic stab_bad,
        input logic data_bad,
        input logic user_bad,
        input logic last_bad,
        input logic timed_out
    );
        if (link_drop)      return ERR_LINK;
        else if (stab_bad)  return ERR_STABLE;
        else if (data_bad)  return ERR_DATA;
        else if (user_bad)  return ERR_USER;
        else if (last_bad)  return ERR_LAST;
        else if (timed_out) return ERR_TIMEOUT;
        else                return ERR_NONE;
    endfunction

endpackage

// File: rtl/ponylink_rx_checker_if.sv
// AXI-stream beat bundle between the ponylink master out_* port and its checker.
interface ponylink_rx_checker_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 4
);
    logic [TDATA_WIDTH-1:0] out_tdata;
    logic [TUSER_WIDTH-1:0] out_tuser;
    logic                   out_tvalid;
    logic                   out_tlast;
    logic                   out_tready;

    // Stream producer side
    modport master (
        output out_tdata, out_tuser, out_tvalid, out_tlast,
        input  out_tready
    );

    // Stream consumer side (the checker)
    modport slave (
        input  out_tdata, out_tuser, out_tvalid, out_tlast,
        output out_tready
    );
endinterface

// File: rtl/ponylink_rx_checker_expect_gen.sv
// Expected beat contents as a pure function of the beat index.
module ponylink_rx_expect_gen #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 4,
    parameter int NUM_WORDS   = 4,
    parameter int DATA_SEED   = 23,
    parameter int USER_SEED   = 13
) (
    input  logic [7:0]             i_index,
    output logic [TDATA_WIDTH-1:0] o_tdata,
    output logic [TUSER_WIDTH-1:0] o_tuser,
    output logic                   o_tlast
);

    // Seed plus index, wrapping at the field width; tlast marks the final beat
    always_comb begin
        o_tdata = TDATA_WIDTH'(DATA_SEED) + TDATA_WIDTH'(i_index);
        o_tuser = TUSER_WIDTH'(USER_SEED) + TUSER_WIDTH'(i_index);
        o_tlast = (i_index == 8'(NUM_WORDS - 1));
    end

endmodule

// File: rtl/ponylink_rx_checker.sv
// Receive-side stream checker: applies rotating backpressure, checks every
// accepted beat against a counter sequence, and latches the first failure.
module ponylink_rx_checker
    import ponylink_chk_pkg::*;
#(
    parameter int         TDATA_WIDTH   = 8,
    parameter int         TUSER_WIDTH   = 4,
    parameter int         NUM_WORDS     = 4,
    parameter int         DATA_SEED     = 23,
    parameter int         USER_SEED     = 13,
    parameter logic [7:0] READY_PATTERN = 8'b10110110,
    parameter int         TIMEOUT       = 1023
) (
    input  logic                  master_clk,
    input  logic                  reset,
    input  logic                  resetn_in,
    input  logic                  linkready,
    ponylink_rx_checker_if.slave  axis,
    output logic                  finish,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic [7:0]            word_count
);

    chk_state_t r_state;
    chk_state_t w_state_next;

    logic [7:0]             r_pattern;
    logic [7:0]             r_word_count;
    logic [9:0]             r_timeout;
    logic                   r_finish;
    logic                   r_error;
    logic [2:0]             r_err_code;

    logic                   r_prev_stall;
    logic [TDATA_WIDTH-1:0] r_prev_tdata;
    logic [TUSER_WIDTH-1:0] r_prev_tuser;
    logic                   r_prev_tlast;

    logic [TDATA_WIDTH-1:0] w_exp_tdata;
    logic [TUSER_WIDTH-1:0] w_exp_tuser;
    logic                   w_exp_tlast;

    logic                   w_tready;
    logic                   w_hs;
    logic                   w_stab_bad;
    logic                   w_data_bad;
    logic                   w_user_bad;
    logic                   w_last_bad;
    logic                   w_tout;
    logic [2:0]             w_run_code;
    logic [2:0]             w_err_next;
    logic                   w_accept;

    ponylink_rx_expect_gen #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH),
        .NUM_WORDS   (NUM_WORDS),
        .DATA_SEED   (DATA_SEED),
        .USER_SEED   (USER_SEED)
    ) u_expect (
        .i_index (r_word_count),
        .o_tdata (w_exp_tdata),
        .o_tuser (w_exp_tuser),
        .o_tlast (w_exp_tlast)
    );

    // Ready is decoded from registers only, and the RUN-cycle checks it feeds
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            ST_RUN:  w_tready = r_pattern[0];
            ST_DONE: w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
        w_hs       = axis.out_tvalid && w_tready;
        w_stab_bad = r_prev_stall &&
                     (!axis.out_tvalid ||
                      (axis.out_tdata != r_prev_tdata) ||
                      (axis.out_tuser != r_prev_tuser) ||
                      (axis.out_tlast != r_prev_tlast));
        w_data_bad = w_hs && (axis.out_tdata != w_exp_tdata);
        w_user_bad = w_hs && (axis.out_tuser != w_exp_tuser);
        w_last_bad = w_hs && (axis.out_tlast != w_exp_tlast);
        w_tout     = !w_hs && (r_timeout == 10'(TIMEOUT - 1));
        w_run_code = err_select(!resetn_in, w_stab_bad, w_data_bad,
                                w_user_bad, w_last_bad, w_tout);
    end

    // Next-state selection and the cause carried into FAIL
    always_comb begin
        w_state_next = r_state;
        w_err_next   = ERR_NONE;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (resetn_in && linkready)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_code != ERR_NONE) begin
                    w_state_next = ST_FAIL;
                    w_err_next   = w_run_code;
                end else if (w_hs) begin
                    w_accept = 1'b1;
                    if (r_word_count == 8'(NUM_WORDS - 1))
                        w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (axis.out_tvalid) begin
                    w_state_next = ST_FAIL;
                    w_err_next   = ERR_EXTRA;
                end
            end
            ST_FAIL: w_state_next = ST_FAIL;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge master_clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Pattern, counters, stall history and sticky status
    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_pattern    <= READY_PATTERN;
            r_word_count <= '0;
            r_timeout    <= '0;
            r_finish     <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_prev_stall <= 1'b0;
            r_prev_tdata <= '0;
            r_prev_tuser <= '0;
            r_prev_tlast <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_pattern <= {r_pattern[0], r_pattern[7:1]};
                if (w_accept)
                    r_timeout <= '0;
                else if (!w_hs)
                    r_timeout <= r_timeout + 10'd1;
            end
            if (w_accept)
                r_word_count <= r_word_count + 8'd1;
            r_finish     <= (w_state_next == ST_DONE);
            if ((r_state != ST_FAIL) && (w_state_next == ST_FAIL)) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_next;
            end
            r_prev_stall <= (r_state == ST_RUN) && axis.out_tvalid && !w_tready;
            r_prev_tdata <= axis.out_tdata;
            r_prev_tuser <= axis.out_tuser;
            r_prev_tlast <= axis.out_tlast;
        end
    end

    assign axis.out_tready = w_tready;
    assign finish          = r_finish;
    assign error           = r_error;
    assign err_code        = r_err_code;
    assign word_count      = r_word_count;

endmodule

// File: tb/tb_ponylink_rx_checker.sv
// Scoreboard bench: each scenario queues the status snapshots it expects,
// tagged with the cycle they must appear on; a monitor pops on every change.
module tb_ponylink_rx_checker;

    typedef struct {
        logic       f;
        logic       e;
        logic [2:0] code;
        logic [7:0] wc;
        int         cyc;
    } evt_t;

    logic       master_clk;
    logic       reset;
    logic       resetn_in;
    logic       linkready;
    logic       finish;
    logic       error;
    logic [2:0] err_code;
    logic [7:0] word_count;

    ponylink_rx_checker_if #(.TDATA_WIDTH(8), .TUSER_WIDTH(4)) axis ();

    ponylink_rx_checker #(
        .TDATA_WIDTH   (8),
        .TUSER_WIDTH   (4),
        .NUM_WORDS     (4),
        .DATA_SEED     (23),
        .USER_SEED     (13),
        .READY_PATTERN (8'b10110110),
        .TIMEOUT       (1023)
    ) dut (
        .master_clk (master_clk),
        .reset      (reset),
        .resetn_in  (resetn_in),
        .linkready  (linkready),
        .axis       (axis),
        .finish     (finish),
        .error      (error),
        .err_code   (err_code),
        .word_count (word_count)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    evt_t exp_q[$];

    logic [7:0] src_data [0:7];
    logic [3:0] src_user [0:7];
    logic       src_last [0:7];
    int         src_n    = 0;
    int         src_idx  = 0;
    int         src_gap  = -1;
    bit         src_en   = 1'b0;

    initial begin
        master_clk = 1'b0;
        forever #5 master_clk = ~master_clk;
    end

    initial forever begin
        @(posedge master_clk);
        cyc++;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_evt(logic f, logic e, logic [2:0] code,
                                     logic [7:0] wc, int c);
        evt_t ev;
        ev.f = f; ev.e = e; ev.code = code; ev.wc = wc; ev.cyc = c;
        exp_q.push_back(ev);
    endfunction

    // Source: drives the table at each falling edge, advances on handshake
    initial begin
        axis.out_tvalid = 1'b0;
        axis.out_tdata  = '0;
        axis.out_tuser  = '0;
        axis.out_tlast  = 1'b0;
        forever begin
            @(negedge master_clk);
            if (src_en && (src_idx < src_n) && (cyc != src_gap)) begin
                axis.out_tvalid = 1'b1;
                axis.out_tdata  = src_data[src_idx];
                axis.out_tuser  = src_user[src_idx];
                axis.out_tlast  = src_last[src_idx];
            end else begin
                axis.out_tvalid = 1'b0;
            end
            if (axis.out_tvalid && axis.out_tready)
                src_idx++;
        end
    end

    // Monitor: pops one expected snapshot per observed status change
    initial begin
        logic [13:0] prev_snap;
        logic [13:0] now_snap;
        evt_t        ev;
        prev_snap = '0;
        forever begin
            @(negedge master_clk);
            #1;
            now_snap = {finish, error, err_code, word_count};
            if (mon_en) begin
                if (now_snap !== prev_snap) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got f=%0b e=%0b code=%0d wc=%0d at cycle %0d, expected no change",
                                 finish, error, err_code, word_count, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        chk("evt_cycle", cyc, ev.cyc);
                        chk("evt_finish", finish, ev.f);
                        chk("evt_error", error, ev.e);
                        chk("evt_err_code", err_code, ev.code);
                        chk("evt_word_count", word_count, ev.wc);
                    end
                end
                if (error === 1'b1)  chk("tready_in_fail", axis.out_tready, 1'b0);
                if (finish === 1'b1) chk("tready_in_done", axis.out_tready, 1'b1);
            end
            prev_snap = now_snap;
        end
    end

    task automatic load_good(input int n);
        logic [7:0] d [0:4] = '{8'd23, 8'd24, 8'd25, 8'd26, 8'd27};
        logic [3:0] u [0:4] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 5; i++) begin
            src_data[i] = d[i];
            src_user[i] = u[i];
            src_last[i] = (i == 3);
        end
        src_n = n;
    endtask

    // Assert reset at the next falling edge; status returns to zero one edge later
    task automatic rst_begin();
        @(negedge master_clk);
        #2;
        reset   = 1'b1;
        src_en  = 1'b0;
        src_idx = 0;
        src_gap = -1;
        push_evt(1'b0, 1'b0, 3'd0, 8'd0, cyc + 1);
    endtask

    // Release reset; c0 is the cycle index of the release edge
    task automatic rst_end(output int c0);
        repeat (2) @(negedge master_clk);
        #2;
        reset  = 1'b0;
        src_en = 1'b1;
        c0     = cyc;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(negedge master_clk);
        chk("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Beats accepted on RUN cycles 1,2,4,5 (pattern bits 0,1,1,0,1,1,...)
    task automatic push_good_seq(input int c0);
        push_evt(1'b0, 1'b0, 3'd0, 8'd1, c0 + 3);
        push_evt(1'b0, 1'b0, 3'd0, 8'd2, c0 + 4);
        push_evt(1'b0, 1'b0, 3'd0, 8'd3, c0 + 6);
        push_evt(1'b1, 1'b0, 3'd0, 8'd4, c0 + 7);
    endtask

    initial begin
        int c0;
        reset     = 1'b1;
        resetn_in = 1'b1;
        linkready = 1'b1;
        repeat (3) @(negedge master_clk);
        #2;
        chk("rst_tready", axis.out_tready, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_err_code", err_code, 3'd0);
        chk("rst_word_count", word_count, 8'd0);
        mon_en = 1'b1;

        // Clean run
        load_good(4);
        rst_end(c0);
        push_good_seq(c0);
        drain(20);

        // Bad data on beat 1
        rst_begin();
        load_good(4);
        src_data[1] = 8'd99;
        rst_end(c0);
        push_evt(1'b0, 1'b0, 3'd0, 8'd1, c0 + 3);
        push_evt(1'b0, 1'b1, 3'd1, 8'd1, c0 + 4);
        drain(20);

        // tvalid dropped while stalled
        rst_begin();
        load_good(4);
        rst_end(c0);
        src_gap = c0 + 2;
        push_evt(1'b0, 1'b1, 3'd5, 8'd0, c0 + 3);
        drain(20);

        // Silent source: timeout after 1023 RUN cycles
        rst_begin();
        load_good(0);
        rst_end(c0);
        push_evt(1'b0, 1'b1, 3'd4, 8'd0, c0 + 1024);
        drain(1030);

        // Extra beat offered in DONE
        rst_begin();
        load_good(5);
        rst_end(c0);
        push_good_seq(c0);
        push_evt(1'b0, 1'b1, 3'd7, 8'd4, c0 + 8);
        drain(20);

        // Early tlast on the second beat
        rst_begin();
        load_good(4);
        src_last[1] = 1'b1;
        rst_end(c0);
        push_evt(1'b0, 1'b0, 3'd0, 8'd1, c0 + 3);
        push_evt(1'b0, 1'b1, 3'd3, 8'd1, c0 + 4);
        drain(20);

        // Reset mid-RUN coinciding with the third handshake, then full rerun
        rst_begin();
        load_good(4);
        rst_end(c0);
        push_evt(1'b0, 1'b0, 3'd0, 8'd1, c0 + 3);
        push_evt(1'b0, 1'b0, 3'd0, 8'd2, c0 + 4);
        repeat (4) @(negedge master_clk);
        rst_begin();
        load_good(4);
        rst_end(c0);
        push_good_seq(c0);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation reached time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
